// File: rtl/clock_pkg.sv
// Shared types and constants for the clock mode controller.
package clock_pkg;

  typedef enum logic [1:0] {
    NORMAL    = 2'b00,
    SET_TIME  = 2'b01,
    SET_ALARM = 2'b10,
    STOPWATCH = 2'b11
  } mode_e;

  localparam int TIMEOUT_S_DEFAULT = 30;

endpackage

// File: rtl/idle_timer.sv
// Inactivity counter: counts seconds while enabled, flags the last second.
module idle_timer
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = TIMEOUT_S_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  input  logic tick,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT_S - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && tick) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Independent of clear so the owner can fold it into clear safely.
  assign expired = tick && count_en && (cnt == LAST);

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for a digital clock: mode button cycling, edit
// tracking with commit pulses, and inactivity auto-return to NORMAL.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = TIMEOUT_S_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_key,
  input  logic       shift_key,
  input  logic       inc_key,
  input  logic       tick_1hz,
  output logic [1:0] mode,
  output logic       set_time_en,
  output logic       set_alarm_en,
  output logic       stopwatch_en,
  output logic       time_run_en,
  output logic       load_time,
  output logic       load_alarm
);

  mode_e state, state_n;
  logic  edited, edited_n;
  logic  load_time_n, load_alarm_n;
  logic  key_any, in_edit, timeout;
  logic  leave, edit_now;
  logic  expired, clear;

  idle_timer #(
    .TIMEOUT_S(TIMEOUT_S)
  ) u_idle (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .count_en(in_edit),
    .tick    (tick_1hz),
    .expired (expired)
  );

  always_comb begin
    key_any  = mode_key | shift_key | inc_key;
    in_edit  = (state == SET_TIME) || (state == SET_ALARM);
    timeout  = expired & ~key_any;
    state_n  = state;
    unique case (1'b1)
      mode_key: state_n = mode_e'(2'(state + 2'd1));
      timeout:  state_n = NORMAL;
      default:  state_n = state;
    endcase
    leave        = (state_n != state);
    edit_now     = edited | (in_edit & inc_key);
    edited_n     = leave ? 1'b0 : edit_now;
    load_time_n  = leave & (state == SET_TIME) & edit_now;
    load_alarm_n = leave & (state == SET_ALARM) & edit_now;
    clear        = key_any | ~in_edit | timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= NORMAL;
      edited       <= 1'b0;
      set_time_en  <= 1'b0;
      set_alarm_en <= 1'b0;
      stopwatch_en <= 1'b0;
      time_run_en  <= 1'b1;
      load_time    <= 1'b0;
      load_alarm   <= 1'b0;
    end else begin
      state        <= state_n;
      edited       <= edited_n;
      set_time_en  <= (state_n == SET_TIME);
      set_alarm_en <= (state_n == SET_ALARM);
      stopwatch_en <= (state_n == STOPWATCH);
      time_run_en  <= (state_n != SET_TIME);
      load_time    <= load_time_n;
      load_alarm   <= load_alarm_n;
    end
  end

  assign mode = state;

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_S, default 30, inactivity seconds before auto-return to NORMAL (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  system clock, single clock domain.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: mode_key  input  1  debounced one-cycle mode button pulse.
REQ-005 SHALL have port: shift_key  input  1  debounced one-cycle field-shift pulse; activity only.
REQ-006 SHALL have port: inc_key  input  1  debounced one-cycle increment pulse; activity and edit marker.
REQ-007 SHALL have port: tick_1hz  input  1  one-cycle pulse once per second.
REQ-008 SHALL have port: mode  output  2  current mode encoding.
REQ-009 SHALL have port: set_time_en  output  1  high while in SET_TIME; drives time_set.
REQ-010 SHALL have port: set_alarm_en  output  1  high while in SET_ALARM.
REQ-011 SHALL have port: stopwatch_en  output  1  high while in STOPWATCH.
REQ-012 SHALL have port: time_run_en  output  1  low while in SET_TIME, else high; gates time counter.
REQ-013 SHALL have port: load_time  output  1  one-cycle commit pulse for edited time.
REQ-014 SHALL have port: load_alarm  output  1  one-cycle commit pulse for edited alarm.

Function
REQ-015 SHALL implement four states: NORMAL=2'b00, SET_TIME=2'b01, SET_ALARM=2'b10, STOPWATCH=2'b11; mode equals state.
REQ-016 SHALL advance on mode_key: NORMAL->SET_TIME->SET_ALARM->STOPWATCH->NORMAL; new state visible the cycle after the pulse.
REQ-017 SHALL derive all outputs from registers; mode/enables change in the same cycle as the state register.
REQ-018 SHALL keep an 8-bit idle counter: cleared on any key pulse or state change; incremented on tick_1hz only in SET_TIME or SET_ALARM.
REQ-019 SHALL, when tick_1hz arrives with idle counter == TIMEOUT_S-1 in SET_TIME or SET_ALARM and no key pulse that cycle, move to NORMAL next cycle.
REQ-020 SHALL never time out in NORMAL or STOPWATCH; idle counter held at 0 there.
REQ-021 SHALL keep an edited flag: cleared on entry to SET_TIME or SET_ALARM; set by inc_key in those states; ignored elsewhere.
REQ-022 SHALL pulse load_time for exactly one cycle, concurrent with the first cycle of the new state, when leaving SET_TIME (mode_key or timeout) with edited set.
REQ-023 SHALL pulse load_alarm likewise when leaving SET_ALARM with edited set; no pulse if unedited.
REQ-024 SHALL, for inc_key and mode_key in the same cycle in SET_TIME/SET_ALARM, count the edit: transition occurs and the load pulse is emitted.
REQ-025 SHALL give mode_key priority over timeout in the same cycle: state advances per REQ-016, not to NORMAL.
REQ-026 SHALL never assert load_time and load_alarm simultaneously.

Reset
REQ-027 SHALL, on rst_n low at a clk edge: state NORMAL, mode 2'b00, set_time_en/set_alarm_en/stopwatch_en 0, time_run_en 1, load_time/load_alarm 0, idle counter 0, edited 0.
REQ-028 SHALL discard an in-progress edit on reset: no load pulse after reset release.
REQ-029 SHALL ignore all key and tick inputs during reset.

Structure
REQ-030 SHALL take the mode enum (four encodings) and the default TIMEOUT_S constant from shared package clock_pkg.
REQ-031 SHALL place the idle counter in one sub-module, idle_timer (inputs clear, count_en, tick; output expired).
REQ-032 SHALL fit 120-400 lines of RTL total.

Verification
REQ-033 SHALL cover: after reset, 4 mode_key pulses spaced 3 cycles -> mode 01,10,11,00, each one cycle after its pulse, no load pulses.
REQ-034 SHALL cover: TIMEOUT_S=3, enter SET_TIME, inc_key once, 3 ticks -> NORMAL after third tick, load_time high exactly 1 cycle, time_run_en returns 1.
REQ-035 SHALL cover: enter SET_ALARM, 2 ticks, shift_key, 2 ticks (TIMEOUT_S=3) -> stays SET_ALARM; third tick after shift -> NORMAL, load_alarm never asserted.
REQ-036 SHALL cover: SET_TIME with inc_key and mode_key in same cycle -> SET_ALARM next cycle with load_time=1 that cycle.
REQ-037 SHALL cover: SET_TIME idle counter at TIMEOUT_S-1, mode_key coincident with tick -> SET_ALARM, not NORMAL.
REQ-038 SHALL cover: edited SET_TIME, rst_n low 1 cycle -> NORMAL, all outputs at reset values, no load_time afterwards.
